// File: rtl/ifft_fmt_pkg.sv
// Shared definitions for the IFFT output formatter.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Provides frame error codes, output buffer depth and FSM states.
package ifft_fmt_pkg;

  localparam logic [1:0] ERR_OK    = 2'b00;  // frame length matched
  localparam logic [1:0] ERR_SHORT = 2'b01;  // eop arrived before fftpts beats
  localparam logic [1:0] ERR_LONG  = 2'b10;  // fftpts beats seen without eop
  localparam logic [1:0] ERR_NOEOP = 2'b11;  // sop arrived inside an open frame

  localparam int FIFO_DEPTH = 3;

  typedef enum logic {
    ST_IDLE,
    ST_INFRAME
  } state_t;

endpackage

// File: rtl/ifft_out_formatter_if.sv
// Avalon-ST style complex sample stream with frame side-band.
// Latency: n/a (wires only).
// Backpressure: master holds a beat until valid & ready.
// Fields: valid/ready handshake, error, sop/eop, re/im samples, pts (frame length),
// shift (scaling amount), sat_cnt (saturated beats so far in the frame).
interface ifft_out_formatter_if #(
  parameter int DW      = 32,
  parameter int PTS_W   = 12,
  parameter int SHIFT_W = 5
);
  logic                    valid;
  logic                    ready;
  logic [1:0]              error;
  logic                    sop;
  logic                    eop;
  logic signed [DW-1:0]    re;
  logic signed [DW-1:0]    im;
  logic [PTS_W-1:0]        pts;
  logic [SHIFT_W-1:0]      shift;
  logic [PTS_W-1:0]        sat_cnt;

  modport master (
    output valid, error, sop, eop, re, im, pts, shift, sat_cnt,
    input  ready
  );

  modport slave (
    input  valid, error, sop, eop, re, im, pts, shift, sat_cnt,
    output ready
  );
endinterface

// File: rtl/ifft_round_sat.sv
// Arithmetic right shift with round-half-up, then saturation to OUT_W.
// Latency: combinational.
// Backpressure: none. Ports: x in, shift in (clamped to IN_W-1), y out, sat = value clipped.
module ifft_round_sat #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic [SHIFT_W-1:0]      shift,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [31:0]            s;
  logic [IN_W:0]          rnd;
  logic signed [IN_W:0]   sum;
  logic signed [IN_W:0]   r;

  always_comb begin
    s = (32'(shift) > 32'(IN_W-1)) ? 32'(IN_W-1) : 32'(shift);
    rnd = '0;
    if (s != 32'd0) rnd = (IN_W+1)'(1) << (s - 32'd1);
    // One extra bit so x + half-LSB cannot wrap.
    sum = $signed({x[IN_W-1], x}) + $signed(rnd);
    r   = sum >>> s;
    sat = 1'b0;
    y   = r[OUT_W-1:0];
    if (r > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (r < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/ifft_out_formatter.sv
// Scales IFFT output (shift/round/saturate), checks frame length against fftpts, buffers 3 beats.
// Latency: 2 cycles from accepted sink beat to source valid (stage A register, then FIFO head).
// Backpressure: sink ready = (fifo_cnt + stage A) < 3, from registers only; full rate when source ready.
// Ports: clk, reset (async, active high), sink (slave stream, IN_W), source (master stream, OUT_W).
module ifft_out_formatter
  import ifft_fmt_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 16,
  parameter int PTS_W   = 12,
  parameter int SHIFT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  ifft_out_formatter_if.slave  sink,
  ifft_out_formatter_if.master source
);

  typedef struct packed {
    logic [1:0]              error;
    logic                    sop;
    logic                    eop;
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
    logic [PTS_W-1:0]        pts;
    logic [PTS_W-1:0]        sat_cnt;
  } beat_t;

  localparam logic [1:0] LAST_IDX = 2'(FIFO_DEPTH-1);

  state_t             state_q, state_d;
  logic [PTS_W-1:0]   cnt_q, cnt_d, pts_q, pts_d, sat_q, sat_d;
  logic [SHIFT_W-1:0] shift_q, shift_d, shift_eff;
  logic               run_q;

  logic               a_vld_q;
  beat_t              a_q, beat_d;
  beat_t              mem [FIFO_DEPTH];
  logic [1:0]         wr_ptr, rd_ptr, fifo_cnt;

  logic               accept, fwd, push, pop;
  logic signed [OUT_W-1:0] re_s, im_s;
  logic               re_sat, im_sat;

  // Locals of the frame process
  logic [PTS_W-1:0]   pts_eff, cnt_new, sat_base;
  logic               last;
  logic [1:0]         err;

  // run_q keeps sink ready low while reset is asserted and for no longer.
  assign sink.ready = run_q && ((3'(fifo_cnt) + 3'(a_vld_q)) < 3'(FIFO_DEPTH));
  assign accept     = sink.valid && sink.ready;
  assign push       = a_vld_q && (fifo_cnt != 2'(FIFO_DEPTH));
  assign pop        = (fifo_cnt != 2'd0) && source.ready;

  // The sop beat already uses its own shift; later beats use the latched one.
  assign shift_eff = sink.sop ? sink.shift : shift_q;

  ifft_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rs_re (
    .x(sink.re), .shift(shift_eff), .y(re_s), .sat(re_sat)
  );
  ifft_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rs_im (
    .x(sink.im), .shift(shift_eff), .y(im_s), .sat(im_sat)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pts_d    = pts_q;
    shift_d  = shift_q;
    sat_d    = sat_q;
    fwd      = 1'b0;
    beat_d   = '0;
    pts_eff  = pts_q;
    cnt_new  = cnt_q + PTS_W'(1);
    sat_base = sat_q;
    last     = 1'b0;
    err      = ERR_OK;
    // Beats outside a frame that are not sop are accepted and dropped.
    if (accept && (sink.sop || state_q == ST_INFRAME)) begin
      fwd = 1'b1;
      if (sink.sop) begin
        pts_eff  = (sink.pts == '0) ? PTS_W'(1) : sink.pts;
        cnt_new  = PTS_W'(1);
        shift_d  = sink.shift;
        sat_base = '0;
      end
      pts_d = pts_eff;
      cnt_d = cnt_new;
      last  = sink.eop || (cnt_new == pts_eff);
      if (sink.sop && state_q == ST_INFRAME)   err = ERR_NOEOP;
      else if (last && !sink.eop)              err = ERR_LONG;
      else if (sink.eop && cnt_new != pts_eff) err = ERR_SHORT;
      sat_d = (sat_base == '1) ? sat_base : sat_base + PTS_W'(re_sat | im_sat);
      state_d        = last ? ST_IDLE : ST_INFRAME;
      beat_d.error   = err | sink.error;
      beat_d.sop     = sink.sop;
      beat_d.eop     = last;
      beat_d.re      = re_s;
      beat_d.im      = im_s;
      beat_d.pts     = pts_eff;
      beat_d.sat_cnt = sat_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pts_q   <= '0;
      shift_q <= '0;
      sat_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pts_q   <= pts_d;
      shift_q <= shift_d;
      sat_q   <= sat_d;
      run_q   <= 1'b1;
    end
  end

  // Stage A is always free when a beat is accepted: ready implies it drains this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_vld_q  <= 1'b0;
      a_q      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      a_vld_q <= fwd || (a_vld_q && !push);
      if (fwd) a_q <= beat_d;
      if (push) begin
        mem[wr_ptr] <= a_q;
        wr_ptr      <= (wr_ptr == LAST_IDX) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_IDX) ? 2'd0 : rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign source.valid   = (fifo_cnt != 2'd0);
  assign source.error   = mem[rd_ptr].error;
  assign source.sop     = mem[rd_ptr].sop;
  assign source.eop     = mem[rd_ptr].eop;
  assign source.re      = mem[rd_ptr].re;
  assign source.im      = mem[rd_ptr].im;
  assign source.pts     = mem[rd_ptr].pts;
  assign source.sat_cnt = mem[rd_ptr].sat_cnt;
  assign source.shift   = shift_q;

endmodule

// File: tb/tb_ifft_out_formatter.sv
// Directed bench for ifft_out_formatter: hand-computed output beats compared in order.
// Latency: checks 2-cycle sink-to-source latency and full-rate acceptance.
// Backpressure: exercises random source ready and reset in the middle of a frame.
module tb_ifft_out_formatter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifft_out_formatter_if #(.DW(32), .PTS_W(12), .SHIFT_W(5)) sink ();
  ifft_out_formatter_if #(.DW(16), .PTS_W(12), .SHIFT_W(5)) src ();

  ifft_out_formatter #(.IN_W(32), .OUT_W(16), .PTS_W(12), .SHIFT_W(5)) dut (
    .clk(clk), .reset(reset), .sink(sink), .source(src)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  err;
    logic [15:0] re;
    logic [15:0] im;
    logic [11:0] pts;
    logic [11:0] sat;
  } obeat_t;

  obeat_t got_q[$];
  obeat_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stalls = 0;
  int t0;
  logic done;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (!reset && src.valid && src.ready)
      got_q.push_back({src.sop, src.eop, src.error, src.re, src.im, src.pts, src.sat_cnt});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void exp_beat(input logic sop, input logic eop, input logic [1:0] err,
                                   input logic [15:0] re, input logic [15:0] im,
                                   input logic [11:0] pts, input logic [11:0] sat);
    exp_q.push_back({sop, eop, err, re, im, pts, sat});
  endfunction

  task automatic send(input logic sop, input logic eop, input logic [31:0] re,
                      input logic [31:0] im, input logic [11:0] pts, input logic [4:0] sh,
                      input logic [1:0] er);
    logic acc;
    int   guard;
    sink.valid = 1'b1; sink.sop = sop; sink.eop = eop; sink.re = re; sink.im = im;
    sink.pts = pts; sink.shift = sh; sink.error = er;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = sink.ready;
      if (!acc) stalls++;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
    sink.valid = 1'b0; sink.sop = 1'b0; sink.eop = 1'b0; sink.error = 2'b00;
  endtask

  task automatic expect_frames(input string tag);
    int guard;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 500) begin
      @(posedge clk); guard++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sink.valid = 1'b0; sink.sop = 1'b0; sink.eop = 1'b0; sink.re = '0; sink.im = '0;
    sink.pts = '0; sink.shift = '0; sink.error = '0; sink.sat_cnt = '0;
    src.ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sink_ready", 64'(sink.ready), 64'(0));
    check("rst_src_valid", 64'(src.valid), 64'(0));
    check("rst_src_re", 64'(src.re), 64'(0));
    check("rst_src_sat", 64'(src.sat_cnt), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", 64'(sink.ready), 64'(1));
    src.ready = 1'b1;

    // Latency: valid appears two edges after acceptance
    send(1, 1, 32'd5, 32'd5, 12'd1, 5'd0, 2'b00);
    exp_beat(1, 1, 2'b00, 16'd5, 16'd5, 12'd1, 12'd0);
    check("lat_cycle1", 64'(src.valid), 64'(0));
    @(posedge clk); #1;
    check("lat_cycle2", 64'(src.valid), 64'(1));
    expect_frames("lat");

    // pts 8, shift 4 (latched on sop only), 24 -> 2, -24 -> -1
    for (int i = 1; i <= 8; i++) begin
      send(i == 1, i == 8, 32'd24, 32'hFFFF_FFE8, (i == 1) ? 12'd8 : 12'd0,
           (i == 1) ? 5'd4 : 5'd0, 2'b00);
      exp_beat(i == 1, i == 8, 2'b00, 16'd2, 16'hFFFF, 12'd8, 12'd0);
    end
    expect_frames("scale");

    // Saturation of both components
    send(1, 1, 32'd65536, 32'hFFFE_EE90, 12'd1, 5'd0, 2'b00);
    exp_beat(1, 1, 2'b00, 16'h7FFF, 16'h8000, 12'd1, 12'd1);
    expect_frames("sat1");

    // sat_cnt accumulates through a frame
    send(1, 0, 32'd65536, 32'd0, 12'd3, 5'd0, 2'b00);
    send(0, 0, 32'd1, 32'd1, 12'd0, 5'd0, 2'b00);
    send(0, 1, 32'd0, 32'hFFFF_63C0, 12'd0, 5'd0, 2'b00);
    exp_beat(1, 0, 2'b00, 16'h7FFF, 16'd0, 12'd3, 12'd1);
    exp_beat(0, 0, 2'b00, 16'd1, 16'd1, 12'd3, 12'd1);
    exp_beat(0, 1, 2'b00, 16'd0, 16'h8000, 12'd3, 12'd2);
    expect_frames("satcnt");

    // Short frame: eop on beat 5 of 8, then a normal frame with shift 1
    for (int i = 1; i <= 5; i++) begin
      send(i == 1, i == 5, 32'(i), 32'(-i), 12'd8, 5'd0, 2'b00);
      exp_beat(i == 1, i == 5, (i == 5) ? 2'b01 : 2'b00, 16'(i), 16'(-i), 12'd8, 12'd0);
    end
    send(1, 0, 32'd3, 32'hFFFF_FFFD, 12'd2, 5'd1, 2'b00);
    send(0, 1, 32'd3, 32'hFFFF_FFFD, 12'd2, 5'd0, 2'b00);
    exp_beat(1, 0, 2'b00, 16'd2, 16'hFFFF, 12'd2, 12'd0);
    exp_beat(0, 1, 2'b00, 16'd2, 16'hFFFF, 12'd2, 12'd0);
    expect_frames("short");

    // Long frame: pts 4, six beats without eop, beats 5 and 6 dropped
    for (int i = 1; i <= 6; i++) send(i == 1, 0, 32'(i), 32'(i), 12'd4, 5'd0, 2'b00);
    for (int i = 1; i <= 4; i++)
      exp_beat(i == 1, i == 4, (i == 4) ? 2'b10 : 2'b00, 16'(i), 16'(i), 12'd4, 12'd0);
    expect_frames("long");

    // sop inside an open frame, plus sink error pass-through
    send(1, 0, 32'd1, 32'd1, 12'd4, 5'd0, 2'b00);
    send(0, 0, 32'd2, 32'd2, 12'd0, 5'd0, 2'b00);
    send(1, 0, 32'd3, 32'd3, 12'd3, 5'd0, 2'b00);
    send(0, 0, 32'd4, 32'd4, 12'd0, 5'd0, 2'b10);
    send(0, 1, 32'd5, 32'd5, 12'd0, 5'd0, 2'b00);
    exp_beat(1, 0, 2'b00, 16'd1, 16'd1, 12'd4, 12'd0);
    exp_beat(0, 0, 2'b00, 16'd2, 16'd2, 12'd4, 12'd0);
    exp_beat(1, 0, 2'b11, 16'd3, 16'd3, 12'd3, 12'd0);
    exp_beat(0, 0, 2'b10, 16'd4, 16'd4, 12'd3, 12'd0);
    exp_beat(0, 1, 2'b00, 16'd5, 16'd5, 12'd3, 12'd0);
    expect_frames("noeop");

    // Maximum shift rounding, and pts 0 treated as 1
    send(1, 0, 32'h4000_0000, 32'h3FFF_FFFF, 12'd2, 5'd31, 2'b00);
    send(0, 1, 32'hC000_0000, 32'hBFFF_FFFF, 12'd0, 5'd0, 2'b00);
    send(1, 1, 32'd9, 32'd9, 12'd0, 5'd0, 2'b00);
    exp_beat(1, 0, 2'b00, 16'd1, 16'd0, 12'd2, 12'd0);
    exp_beat(0, 1, 2'b00, 16'd0, 16'hFFFF, 12'd2, 12'd0);
    exp_beat(1, 1, 2'b00, 16'd9, 16'd9, 12'd1, 12'd0);
    expect_frames("edge");

    // 64-beat frame with random downstream ready
    done = 1'b0;
    fork
      begin
        for (int i = 1; i <= 64; i++)
          send(i == 1, i == 64, 32'(i), 32'(-i), 12'd64, 5'd0, 2'b00);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          src.ready = 1'($urandom_range(0, 1));
        end
        src.ready = 1'b1;
      end
    join
    for (int i = 1; i <= 64; i++)
      exp_beat(i == 1, i == 64, 2'b00, 16'(i), 16'(-i), 12'd64, 12'd0);
    expect_frames("random");

    // Full throughput with ready held high
    src.ready = 1'b1;
    stalls = 0;
    t0 = cyc;
    for (int i = 1; i <= 16; i++) begin
      send(i == 1, i == 16, 32'(100 + i), 32'(i), 12'd16, 5'd0, 2'b00);
      exp_beat(i == 1, i == 16, 2'b00, 16'(100 + i), 16'(i), 12'd16, 12'd0);
    end
    check("thru_cycles", 64'(cyc - t0), 64'(16));
    check("thru_stalls", 64'(stalls), 64'(0));
    expect_frames("thru");

    // Reset in the middle of a frame
    src.ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(i == 1, 0, 32'(i), 32'(i), 12'd8, 5'd0, 2'b00);
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(src.valid), 64'(0));
    check("midrst_ready", 64'(sink.ready), 64'(0));
    check("midrst_re", 64'(src.re), 64'(0));
    check("midrst_sop", 64'(src.sop), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    src.ready = 1'b1;
    send(1, 0, 32'd7, 32'd7, 12'd2, 5'd0, 2'b00);
    send(0, 1, 32'd8, 32'd8, 12'd0, 5'd0, 2'b00);
    exp_beat(1, 0, 2'b00, 16'd7, 16'd7, 12'd2, 12'd0);
    exp_beat(0, 1, 2'b00, 16'd8, 16'd8, 12'd2, 12'd0);
    expect_frames("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
